updown_mod_counter: RTL and testbench



---
 rtl/udc_pkg.sv | 22 ++
 rtl/udc_prescaler.sv | 33 +++
 rtl/updown_mod_counter.sv | 107 ++++++++++
 tb/tb_updown_mod_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/udc_pkg.sv
// Shared types and helpers for the up/down modulus counter.
package udc_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_PRESC_W = 4;

  // What the counter does on a given edge when no clear/load is pending
  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_INC,
    STEP_DEC,
    STEP_WRAP_LO,
    STEP_WRAP_HI,
    STEP_SAT
  } step_e;

  // Limit a value to the 0..mod range
  function automatic logic [31:0] clamp_to_mod(input logic [31:0] val, input logic [31:0] mod);
    return (val > mod) ? mod : val;
  endfunction

endpackage

// File: rtl/udc_prescaler.sv
// Step prescaler: counts enabled cycles 0..presc_div and ticks on the last one.
module udc_prescaler
  import udc_pkg::*;
#(
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc_div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;
  logic               last_c;

  // Terminal compare uses >= so a shrinking presc_div cannot strand the counter
  assign last_c = (cnt >= presc_div);
  assign tick   = en & last_c & ~clr;

  // Prescaler count: cleared by clr, frozen while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last_c ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with runtime modulus, clear, load and wrap/saturate control.
// Optional step prescaler enabled by defining UDC_PRESCALE_EN.
module updown_mod_counter
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned RST_VAL = 0,
  parameter int unsigned PRESC_W = DEF_PRESC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap
`ifdef UDC_PRESCALE_EN
  ,
  input  logic [PRESC_W-1:0] presc_div
`endif
);

  logic       step_q_c;
  step_e      step_c;
  logic [WIDTH-1:0] load_clamped_c;

`ifdef UDC_PRESCALE_EN
  logic presc_tick;

  // Clear or load restarts the prescaler period
  udc_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr | load),
    .presc_div (presc_div),
    .tick      (presc_tick)
  );

  assign step_q_c = en & presc_tick;
`else
  logic presc_w_unused;
  assign presc_w_unused = 1'(PRESC_W);
  assign step_q_c       = en;
`endif

  assign load_clamped_c = WIDTH'(clamp_to_mod(32'(load_val), 32'(modulus)));

  // Terminal flags follow the registered count directly
  assign at_max  = (count >= modulus);
  assign at_zero = (count == '0);

  // Step decision for this edge
  always_comb begin
    step_c = STEP_HOLD;
    if (step_q_c) begin
      if (up) begin
        if (count < modulus) step_c = STEP_INC;
        else if (sat)        step_c = STEP_SAT;
        else                 step_c = STEP_WRAP_LO;
      end else begin
        if (count != '0)     step_c = STEP_DEC;
        else if (sat)        step_c = STEP_HOLD;
        else                 step_c = STEP_WRAP_HI;
      end
    end
  end

  // Count and wrap pulse registers; clr beats load beats step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= WIDTH'(RST_VAL);
      wrap  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_clamped_c;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      unique case (step_c)
        STEP_INC:     count <= count + WIDTH'(1);
        STEP_DEC:     count <= count - WIDTH'(1);
        STEP_SAT:     count <= modulus;
        STEP_WRAP_LO: begin
          count <= '0;
          wrap  <= 1'b1;
        end
        STEP_WRAP_HI: begin
          count <= modulus;
          wrap  <= 1'b1;
        end
        default:      count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter (WIDTH=4, RST_VAL=0).
module tb_updown_mod_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, up, clr, load, sat;
  logic [W-1:0] load_val, modulus;
  logic [W-1:0] count;
  logic         at_max, at_zero, wrap;
`ifdef UDC_PRESCALE_EN
  logic [3:0]   presc_div;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  updown_mod_counter #(.WIDTH(W), .RST_VAL(0), .PRESC_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .modulus  (modulus),
    .sat      (sat),
    .count    (count),
    .at_max   (at_max),
    .at_zero  (at_zero),
    .wrap     (wrap)
`ifdef UDC_PRESCALE_EN
    ,
    .presc_div(presc_div)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] exp_cnt, input logic exp_wrap);
    n_tests++;
    if (count !== exp_cnt || wrap !== exp_wrap) begin
      n_fail++;
      $display("FAIL %s: count=%0d wrap=%0b, expected count=%0d wrap=%0b",
               name, count, wrap, exp_cnt, exp_wrap);
    end
  endtask

  task automatic do_clear();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; sat = 1'b0;
    load_val = '0; modulus = 4'd9;
`ifdef UDC_PRESCALE_EN
    presc_div = 4'd0;
`endif
    #12;
    chk("reset", 4'd0, 1'b0);
    n_tests++;
    if (at_zero !== 1'b1 || at_max !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: at_zero=%0b at_max=%0b, expected 1 0", at_zero, at_max);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    modulus = 4'd9; sat = 1'b0; up = 1'b1; en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("up_%0d", i), W'(i), 1'b0);
      n_tests++;
      if (at_max !== (i == 9)) begin
        n_fail++;
        $display("FAIL up_at_max_%0d: at_max=%0b expected %0b", i, at_max, (i == 9));
      end
    end
    tick(); chk("up_wrap", 4'd0, 1'b1);
    tick(); chk("up_after_wrap", 4'd1, 1'b0);
    en = 1'b0;
  endtask

  task automatic test_down();
    do_clear();
    up = 1'b0; sat = 1'b0; en = 1'b1;
    tick(); chk("down_wrap_first", 4'd9, 1'b1);
    for (int i = 8; i >= 0; i--) begin
      tick(); chk($sformatf("down_%0d", i), W'(i), 1'b0);
    end
    tick(); chk("down_wrap_second", 4'd9, 1'b1);
    en = 1'b0; do_clear();
    sat = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("down_sat_%0d", i), 4'd0, 1'b0);
    end
    en = 1'b0; sat = 1'b0;
  endtask

  task automatic test_modulus_change();
    modulus = 4'd9; load_val = 4'd7; load = 1'b1; tick(); load = 1'b0;
    chk("mod_load7", 4'd7, 1'b0);
    modulus = 4'd4; up = 1'b1; sat = 1'b0; en = 1'b1;
    tick(); chk("mod_shrink_wrap", 4'd0, 1'b1);
    en = 1'b0; modulus = 4'd9; load = 1'b1; tick(); load = 1'b0;
    modulus = 4'd4; sat = 1'b1; en = 1'b1;
    tick(); chk("mod_shrink_sat", 4'd4, 1'b0);
    // Out-of-range count walks down one step at a time
    en = 1'b0; modulus = 4'd9; load = 1'b1; tick(); load = 1'b0;
    modulus = 4'd5; up = 1'b0; sat = 1'b0; en = 1'b1;
    tick(); chk("mod_walk_down", 4'd6, 1'b0);
    en = 1'b0; sat = 1'b0;
  endtask

  task automatic test_priority();
    modulus = 4'd9; up = 1'b1;
    load = 1'b1; load_val = 4'd5; tick();
    clr = 1'b1; load = 1'b1; load_val = 4'd12; en = 1'b1;
    tick(); chk("prio_clr_wins", 4'd0, 1'b0);
    clr = 1'b0; en = 1'b0;
    tick(); chk("prio_load_clamp", 4'd9, 1'b0);
    load_val = 4'd3; en = 1'b1;
    tick(); chk("prio_load_over_step", 4'd3, 1'b0);
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_mod_zero();
    do_clear();
    modulus = 4'd0; sat = 1'b0; up = 1'b1; en = 1'b1;
    tick(); chk("mod0_up_wrap1", 4'd0, 1'b1);
    tick(); chk("mod0_up_wrap2", 4'd0, 1'b1);
    up = 1'b0;
    tick(); chk("mod0_down_wrap", 4'd0, 1'b1);
    sat = 1'b1;
    tick(); chk("mod0_sat_down", 4'd0, 1'b0);
    up = 1'b1;
    tick(); chk("mod0_sat_up", 4'd0, 1'b0);
    en = 1'b0; sat = 1'b0; modulus = 4'd9;
  endtask

  task automatic test_async_reset();
    do_clear();
    up = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("async_pre", 4'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_mid_count", 4'd0, 1'b0);
    tick(); chk("async_held", 4'd0, 1'b0);
    rst_n = 1'b1;
    // Create a wrap pulse with a non-reset count, then reset between edges
    en = 1'b0; do_clear();
    up = 1'b0; en = 1'b1;
    tick(); chk("async_wrap_pre", 4'd9, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_wrap_clear", 4'd0, 1'b0);
    up = 1'b1;
    #2 rst_n = 1'b1;
    tick(); chk("async_resume", 4'd1, 1'b0);
    en = 1'b0;
  endtask

`ifdef UDC_PRESCALE_EN
  task automatic test_prescale();
    modulus = 4'd9; up = 1'b1; sat = 1'b0; presc_div = 4'd2;
    do_clear();
    en = 1'b1;
    tick(); chk("presc_1", 4'd0, 1'b0);
    tick(); chk("presc_2", 4'd0, 1'b0);
    tick(); chk("presc_3", 4'd1, 1'b0);
    tick(); chk("presc_4", 4'd1, 1'b0);
    tick(); chk("presc_5", 4'd1, 1'b0);
    tick(); chk("presc_6", 4'd2, 1'b0);
    tick(); chk("presc_7", 4'd2, 1'b0);
    en = 1'b0;
    tick(); tick(); chk("presc_gated", 4'd2, 1'b0);
    en = 1'b1;
    tick(); chk("presc_8", 4'd2, 1'b0);
    tick(); chk("presc_9", 4'd3, 1'b0);
    en = 1'b0; presc_div = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down();
    test_modulus_change();
    test_priority();
    test_mod_zero();
    test_async_reset();
`ifdef UDC_PRESCALE_EN
    test_prescale();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
